psum_fifo: RTL and testbench

- Elastic buffer between the PE array psum outputs and the accumulator read-modify-write stage.
- Captures one 4-lane psum vector per cycle from the PE array.
- Releases vectors at the accumulator's fixed 3-cycle READ/WAIT/WRITE cadence.
- Drives the accumulator's BRAM_rready (ff_ren) and BRAM_wready (out_psum_vld), and holds the head vector stable for the whole read-modify-write.

---
 rtl/psum_fifo_pkg.sv | 29 ++
 rtl/psum_fifo_if.sv | 43 ++++
 rtl/psum_fifo_ram.sv | 34 +++
 rtl/psum_fifo.sv | 136 +++++++++++++
 tb/tb_psum_fifo.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_fifo_pkg.sv
// ============================================================================
// Module   : psum_fifo_pkg
// Brief    : Shared defaults, issue-FSM encoding and vector-width helper for
//            the psum elastic buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package psum_fifo_pkg;

    localparam int c_PSUM_WIDTH_DEF = 8;
    localparam int c_DEPTH_DEF      = 16;
    localparam int c_DEPTH_BIT_DEF  = 4;

    // Issue states line up with the accumulator's READ / WAIT / WRITE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD1 = 2'd2,
        HOLD2 = 2'd3
    } state_t;

    function automatic int psum_vec_width(input int lane_w);
        return 4 * lane_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/psum_fifo_if.sv
// ============================================================================
// Module   : psum_fifo_if
// Brief    : PE-array push side and accumulator pop side of the psum FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface psum_fifo_if
    import psum_fifo_pkg::*;
#(
    parameter int PSUM_WIDTH = c_PSUM_WIDTH_DEF,
    parameter int DEPTH_BIT  = c_DEPTH_BIT_DEF
);
    logic                  in_vld;
    logic [PSUM_WIDTH-1:0] in_psum0;
    logic [PSUM_WIDTH-1:0] in_psum1;
    logic [PSUM_WIDTH-1:0] in_psum2;
    logic [PSUM_WIDTH-1:0] in_psum3;
    logic                  in_ready;
    logic                  ff_ren;
    logic                  out_psum_vld;
    logic [PSUM_WIDTH-1:0] out_psum0;
    logic [PSUM_WIDTH-1:0] out_psum1;
    logic [PSUM_WIDTH-1:0] out_psum2;
    logic [PSUM_WIDTH-1:0] out_psum3;
    logic [DEPTH_BIT:0]    count;
    logic                  overflow;

    modport master (
        output in_vld, in_psum0, in_psum1, in_psum2, in_psum3,
        input  in_ready, ff_ren, out_psum_vld,
        input  out_psum0, out_psum1, out_psum2, out_psum3, count, overflow
    );

    modport slave (
        input  in_vld, in_psum0, in_psum1, in_psum2, in_psum3,
        output in_ready, ff_ren, out_psum_vld,
        output out_psum0, out_psum1, out_psum2, out_psum3, count, overflow
    );

endinterface

`default_nettype wire

// File: rtl/psum_fifo_ram.sv
// ============================================================================
// Module   : psum_ram
// Brief    : Register-array storage, one synchronous write port and one
//            combinational read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module psum_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [WIDTH-1:0]  wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/psum_fifo.sv
// ============================================================================
// Module   : psum_fifo
// Brief    : Elastic psum buffer releasing one vector per accumulator
//            read-modify-write (ISSUE/HOLD1/HOLD2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module psum_fifo
    import psum_fifo_pkg::*;
#(
    parameter int PSUM_WIDTH = c_PSUM_WIDTH_DEF,
    parameter int DEPTH      = c_DEPTH_DEF,
    parameter int DEPTH_BIT  = c_DEPTH_BIT_DEF
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   flush,
    psum_fifo_if.slave  bus
);

    localparam int                   c_VEC_W   = psum_vec_width(PSUM_WIDTH);
    localparam logic [DEPTH_BIT:0]   c_DEPTH   = (DEPTH_BIT+1)'(DEPTH);
    localparam logic [DEPTH_BIT:0]   c_CNT_ONE = (DEPTH_BIT+1)'(1);
    localparam logic [DEPTH_BIT-1:0] c_PTR_ONE = DEPTH_BIT'(1);

    logic [DEPTH_BIT-1:0] r_wr_ptr;
    logic [DEPTH_BIT-1:0] r_rd_ptr;
    logic [DEPTH_BIT:0]   r_count;
    state_t               r_state;
    logic                 r_ff_ren;
    logic                 r_out_vld;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_ready;
    logic                 w_push;
    logic [DEPTH_BIT:0]   w_count_nxt;
    state_t               w_state_nxt;
    logic [c_VEC_W-1:0]   w_wdata;
    logic [c_VEC_W-1:0]   w_rdata;
    logic [c_VEC_W-1:0]   w_head;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    // The accumulator has consumed the head by the end of HOLD2 (its WRITE).
    assign w_pop   = (r_state == HOLD2);
    assign w_ready = !flush && (!w_full || w_pop);
    assign w_push  = bus.in_vld && w_ready;
    assign w_wdata = {bus.in_psum3, bus.in_psum2, bus.in_psum1, bus.in_psum0};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = HOLD1;
            HOLD1:   w_state_nxt = HOLD2;
            HOLD2:   w_state_nxt = (w_count_nxt != '0) ? ISSUE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= IDLE;
            r_ff_ren   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            // An RMW already in flight finishes in the accumulator on its own.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= IDLE;
            r_ff_ren   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count   <= w_count_nxt;
            r_state   <= w_state_nxt;
            r_ff_ren  <= (w_state_nxt == ISSUE);
            r_out_vld <= (w_state_nxt != IDLE);
            if (bus.in_vld && !w_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    psum_ram #(
        .WIDTH  (c_VEC_W),
        .DEPTH  (DEPTH),
        .ADDR_W (DEPTH_BIT)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    assign w_head = w_empty ? '0 : w_rdata;

    assign bus.in_ready     = w_ready;
    assign bus.ff_ren       = r_ff_ren;
    assign bus.out_psum_vld = r_out_vld;
    assign bus.out_psum0    = w_head[0*PSUM_WIDTH +: PSUM_WIDTH];
    assign bus.out_psum1    = w_head[1*PSUM_WIDTH +: PSUM_WIDTH];
    assign bus.out_psum2    = w_head[2*PSUM_WIDTH +: PSUM_WIDTH];
    assign bus.out_psum3    = w_head[3*PSUM_WIDTH +: PSUM_WIDTH];
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_psum_fifo.sv
// ============================================================================
// Module   : tb_psum_fifo
// Brief    : Directed, table-driven bench for psum_fifo.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_psum_fifo;

    logic clk;
    logic rst;
    logic flush;

    int checks = 0;
    int errors = 0;

    psum_fifo_if #(.PSUM_WIDTH(8), .DEPTH_BIT(4)) bus ();

    psum_fifo #(.PSUM_WIDTH(8), .DEPTH(16), .DEPTH_BIT(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] din;
        logic        ready;
        logic        ff;
        logic        ovld;
        logic [4:0]  cnt;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[25];

    function automatic logic [31:0] vec(input int n);
        logic [7:0] b;
        b = 8'(4 * n);
        return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
    endfunction

    function automatic vec_t row(input logic v, input logic [31:0] d, input logic rdy,
                                 input logic f, input logic ov, input int c,
                                 input logic [31:0] q);
        vec_t r;
        r.vld = v; r.din = d; r.ready = rdy; r.ff = f; r.ovld = ov;
        r.cnt = 5'(c); r.dout = q;
        return r;
    endfunction

    function automatic logic [31:0] head();
        return {bus.out_psum3, bus.out_psum2, bus.out_psum1, bus.out_psum0};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic f);
        bus.in_vld   = v;
        bus.in_psum0 = d[7:0];
        bus.in_psum1 = d[15:8];
        bus.in_psum2 = d[23:16];
        bus.in_psum3 = d[31:24];
        flush        = f;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_idx;

        // Single vector {4,3,2,1} pushed at cycle 0.
        tbl[0] = row(1, vec(0), 1, 0, 0, 0, 32'h0);
        tbl[1] = row(0, 32'h0,  1, 0, 0, 1, vec(0));
        tbl[2] = row(0, 32'h0,  1, 1, 1, 1, vec(0));
        tbl[3] = row(0, 32'h0,  1, 0, 1, 1, vec(0));
        tbl[4] = row(0, 32'h0,  1, 0, 1, 1, vec(0));
        tbl[5] = row(0, 32'h0,  1, 0, 0, 0, 32'h0);
        tbl[6] = row(0, 32'h0,  1, 0, 0, 0, 32'h0);
        // Burst of five back-to-back pushes vec(1)..vec(5).
        tbl[7]  = row(1, vec(1), 1, 0, 0, 0, 32'h0);
        tbl[8]  = row(1, vec(2), 1, 0, 0, 1, vec(1));
        tbl[9]  = row(1, vec(3), 1, 1, 1, 2, vec(1));
        tbl[10] = row(1, vec(4), 1, 0, 1, 3, vec(1));
        tbl[11] = row(1, vec(5), 1, 0, 1, 4, vec(1));
        tbl[12] = row(0, 32'h0,  1, 1, 1, 4, vec(2));
        tbl[13] = row(0, 32'h0,  1, 0, 1, 4, vec(2));
        tbl[14] = row(0, 32'h0,  1, 0, 1, 4, vec(2));
        tbl[15] = row(0, 32'h0,  1, 1, 1, 3, vec(3));
        tbl[16] = row(0, 32'h0,  1, 0, 1, 3, vec(3));
        tbl[17] = row(0, 32'h0,  1, 0, 1, 3, vec(3));
        tbl[18] = row(0, 32'h0,  1, 1, 1, 2, vec(4));
        tbl[19] = row(0, 32'h0,  1, 0, 1, 2, vec(4));
        tbl[20] = row(0, 32'h0,  1, 0, 1, 2, vec(4));
        tbl[21] = row(0, 32'h0,  1, 1, 1, 1, vec(5));
        tbl[22] = row(0, 32'h0,  1, 0, 1, 1, vec(5));
        tbl[23] = row(0, 32'h0,  1, 0, 1, 1, vec(5));
        tbl[24] = row(0, 32'h0,  1, 0, 0, 0, 32'h0);

        rst = 1'b0;
        drive(0, 32'h0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_count", 0, 32'(bus.count), 32'd0);
        chk("rst_ff_ren", 0, 32'(bus.ff_ren), 32'd0);
        chk("rst_vld", 0, 32'(bus.out_psum_vld), 32'd0);
        chk("rst_overflow", 0, 32'(bus.overflow), 32'd0);
        chk("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
        chk("rst_out", 0, head(), 32'h0);
        next_cycle();

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].vld, tbl[i].din, 0);
            @(negedge clk);
            chk("tbl_in_ready", i, 32'(bus.in_ready), 32'(tbl[i].ready));
            chk("tbl_ff_ren", i, 32'(bus.ff_ren), 32'(tbl[i].ff));
            chk("tbl_vld", i, 32'(bus.out_psum_vld), 32'(tbl[i].ovld));
            chk("tbl_count", i, 32'(bus.count), 32'(tbl[i].cnt));
            chk("tbl_out", i, head(), tbl[i].dout);
            next_cycle();
        end

        // Fill: push every cycle; full is reached in a HOLD2 cycle (22), the
        // push at cycle 23 is dropped. Vectors 0..22 must drain in order.
        exp_idx = 0;
        for (int n = 0; n < 24; n++) begin
            drive(1, vec(n), 0);
            @(negedge clk);
            if (n == 21) chk("fill_cnt", n, 32'(bus.count), 32'd15);
            if (n == 22) begin
                chk("full_pop_ready", n, 32'(bus.in_ready), 32'd1);
                chk("full_pop_cnt", n, 32'(bus.count), 32'd16);
                chk("full_pop_ovf", n, 32'(bus.overflow), 32'd0);
            end
            if (n == 23) begin
                chk("full_ready", n, 32'(bus.in_ready), 32'd0);
                chk("full_cnt", n, 32'(bus.count), 32'd16);
            end
            if (bus.ff_ren) begin
                chk("fill_data", exp_idx, head(), (exp_idx < 23) ? vec(exp_idx) : 32'hDEADBEEF);
                exp_idx++;
            end
            next_cycle();
        end
        drive(0, 32'h0, 0);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 0) chk("drop_ovf", c, 32'(bus.overflow), 32'd1);
            if (bus.ff_ren) begin
                chk("fill_data", exp_idx, head(), (exp_idx < 23) ? vec(exp_idx) : 32'hDEADBEEF);
                exp_idx++;
            end
            next_cycle();
        end
        chk("fill_delivered", 0, 32'(exp_idx), 32'd23);
        chk("drain_count", 0, 32'(bus.count), 32'd0);
        chk("ovf_sticky", 0, 32'(bus.overflow), 32'd1);

        // Flush in HOLD1 with count 3, with a push attempted in the same cycle.
        for (int n = 0; n < 3; n++) begin
            drive(1, vec(40 + n), 0);
            next_cycle();
        end
        drive(1, vec(43), 1);
        @(negedge clk);
        chk("flush_ready", 0, 32'(bus.in_ready), 32'd0);
        chk("flush_pre_cnt", 0, 32'(bus.count), 32'd3);
        chk("flush_pre_vld", 0, 32'(bus.out_psum_vld), 32'd1);
        chk("flush_pre_ff", 0, 32'(bus.ff_ren), 32'd0);
        next_cycle();
        drive(0, 32'h0, 0);
        @(negedge clk);
        chk("flush_cnt", 0, 32'(bus.count), 32'd0);
        chk("flush_ovf", 0, 32'(bus.overflow), 32'd0);
        chk("flush_vld", 0, 32'(bus.out_psum_vld), 32'd0);
        chk("flush_out", 0, head(), 32'h0);
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("flush_no_ff", c, 32'(bus.ff_ren), 32'd0);
            chk("flush_no_cnt", c, 32'(bus.count), 32'd0);
            next_cycle();
        end

        // Asynchronous reset during an ISSUE cycle.
        drive(1, vec(50), 0);
        next_cycle();
        drive(1, vec(51), 0);
        next_cycle();
        drive(0, 32'h0, 0);
        @(negedge clk);
        chk("arst_pre_ff", 0, 32'(bus.ff_ren), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ff", 0, 32'(bus.ff_ren), 32'd0);
        chk("arst_vld", 0, 32'(bus.out_psum_vld), 32'd0);
        chk("arst_cnt", 0, 32'(bus.count), 32'd0);
        chk("arst_out", 0, head(), 32'h0);
        next_cycle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        next_cycle();
        drive(1, vec(60), 0);
        @(negedge clk);
        chk("post_c0_ff", 0, 32'(bus.ff_ren), 32'd0);
        next_cycle();
        drive(0, 32'h0, 0);
        @(negedge clk);
        chk("post_c1_ff", 0, 32'(bus.ff_ren), 32'd0);
        chk("post_c1_cnt", 0, 32'(bus.count), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("post_c2_ff", 0, 32'(bus.ff_ren), 32'd1);
        chk("post_c2_out", 0, head(), vec(60));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
